// File: rtl/wt_main_memory.sv
// ============================================================================
// Module   : wt_main_memory
// Brief    : Main-memory responder for the write-through cache: 128-bit block
//            refills and 32-bit word writes with programmable access latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wt_main_memory #(
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [9:0]   req_addr,
    input  logic [31:0]  req_wdata,
    output logic         resp_valid,
    output logic [127:0] resp_rdata,
    output logic         busy
);

    localparam logic [7:0] c_lat_m1 = 8'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_WAIT   = 3'd2,
        S_BEAT   = 3'd3,
        S_COMMIT = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [31:0]    r_mem [0:255];
    logic [7:0]     r_init_cnt;
    logic [7:0]     r_cnt;
    logic [1:0]     r_beat;
    logic           r_write;
    logic [7:0]     r_word;
    logic [31:0]    r_wdata;
    logic [127:0]   r_asm;
    logic [127:0]   w_asm_next;
    logic [31:0]    w_mem_rd;
    logic           w_accept;
    logic           w_unused;

    // Byte offset within a word never selects anything.
    assign w_unused = ^req_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        busy         = 1'b1;
        w_accept     = 1'b0;
        case (r_state)
            S_INIT: begin
                if (r_init_cnt == 8'hFF) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 8'd0) begin
                    w_state_next = r_write ? S_COMMIT : S_BEAT;
                end
            end
            S_BEAT: begin
                if (r_beat == 2'd3) begin
                    w_state_next = S_RESP;
                end
            end
            S_COMMIT: w_state_next = S_RESP;
            S_RESP: begin
                resp_valid   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_INIT;
        endcase
    end

    assign w_mem_rd = r_mem[{r_word[7:2], r_beat}];

    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[{r_beat, 5'd0} +: 32] = w_mem_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_cnt <= 8'd0;
            r_cnt      <= 8'd0;
            r_beat     <= 2'd0;
            r_write    <= 1'b0;
            r_word     <= 8'd0;
            r_wdata    <= 32'd0;
            r_asm      <= 128'd0;
            resp_rdata <= 128'd0;
        end else begin
            case (r_state)
                S_INIT: r_init_cnt <= r_init_cnt + 8'd1;
                S_IDLE: begin
                    if (w_accept) begin
                        r_write <= req_write;
                        r_word  <= req_addr[9:2];
                        r_wdata <= req_wdata;
                        r_cnt   <= c_lat_m1;
                        r_beat  <= 2'd0;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_BEAT: begin
                    r_asm  <= w_asm_next;
                    r_beat <= r_beat + 2'd1;
                    // The last lane lands straight in the response register.
                    if (r_beat == 2'd3) begin
                        resp_rdata <= w_asm_next;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_INIT) begin
                r_mem[r_init_cnt] <= 32'd0;
            end else if (r_state == S_COMMIT) begin
                r_mem[r_word] <= r_wdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wt_main_memory.sv
// ============================================================================
// Module   : tb_wt_main_memory
// Brief    : Self-checking bench for wt_main_memory (LATENCY=4 and LATENCY=1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wt_main_memory;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid4 = 1'b0, valid1 = 1'b0;
    logic         write_i = 1'b0;
    logic [9:0]   addr_i = '0;
    logic [31:0]  wdata_i = '0;
    logic         ready4, ready1, rv4, rv1, busy4, busy1;
    logic [127:0] rdata4, rdata1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0]  model_mem [256];
    logic [127:0] exp_rdata4;
    logic [127:0] exp_rdata1;

    typedef struct {
        bit           wr;
        logic [9:0]   addr;
        logic [31:0]  wdata;
        int           lat;
        logic [127:0] rdata;
    } vec_t;

    vec_t tbl[6];

    always #5 clk = ~clk;

    wt_main_memory #(.LATENCY(4)) dut (
        .clk(clk), .rst(rst), .req_valid(valid4), .req_ready(ready4),
        .req_write(write_i), .req_addr(addr_i), .req_wdata(wdata_i),
        .resp_valid(rv4), .resp_rdata(rdata4), .busy(busy4)
    );

    wt_main_memory #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(valid1), .req_ready(ready1),
        .req_write(write_i), .req_addr(addr_i), .req_wdata(wdata_i),
        .resp_valid(rv1), .resp_rdata(rdata1), .busy(busy1)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] model_block(input logic [9:0] a);
        int b;
        b = int'(a[9:4]) * 4;
        return {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
        exp_rdata4 = '0;
        exp_rdata1 = '0;
    endtask

    // Pulse rst for hold cycles, then expect 256 quiet INIT cycles.
    task automatic do_reset(input int hold, input string nm);
        int quiet_bad;
        rst = 1'b1;
        valid4 = 1'b0;
        valid1 = 1'b0;
        repeat (hold) @(negedge clk);
        rst = 1'b0;
        model_clear();
        quiet_bad = 0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            if (k == 1) check($sformatf("%s_rdata_zero", nm), rdata4, 128'd0);
            if (k < 256 && (ready4 || ready1 || rv4 || rv1 || !busy4 || !busy1)) quiet_bad++;
            if (k == 256) begin
                check($sformatf("%s_ready_at_256", nm), {127'd0, ready4}, 128'd1);
                check($sformatf("%s_busy_low_at_256", nm), {127'd0, busy4}, 128'd0);
                check($sformatf("%s_ready1_at_256", nm), {127'd0, ready1}, 128'd1);
            end
        end
        check($sformatf("%s_init_quiet_cycles", nm), quiet_bad, 0);
    endtask

    task automatic do_req(input bit which, input bit wr, input logic [9:0] a,
                          input logic [31:0] wd, input int exp_lat,
                          input logic [127:0] exp_rd, input string nm);
        int  n;
        bit  got;
        n = 0;
        while (!(which ? ready1 : ready4) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_ready_before", nm), {127'd0, which ? ready1 : ready4}, 128'd1);
        write_i = wr;
        addr_i  = a;
        wdata_i = wd;
        if (which) valid1 = 1'b1; else valid4 = 1'b1;
        n = 0;
        got = 0;
        while (n < 300 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                // Scramble the request lines: the latched copy must be used.
                valid4  = 1'b0;
                valid1  = 1'b0;
                write_i = ~wr;
                addr_i  = 10'($urandom);
                wdata_i = $urandom;
            end
            if (which ? rv1 : rv4) got = 1;
        end
        check($sformatf("%s_latency", nm), n, exp_lat);
        check($sformatf("%s_rdata", nm), which ? rdata1 : rdata4, exp_rd);
        check($sformatf("%s_no_ready_with_resp", nm), {127'd0, which ? ready1 : ready4}, 128'd0);
        @(negedge clk);
        check($sformatf("%s_ready_return", nm), {127'd0, which ? ready1 : ready4}, 128'd1);
    endtask

    initial begin
        int          pulses;
        int          ready_cnt;
        int          p_first;
        int          p_second;
        int          n;
        bit          wr;
        logic [9:0]  a;
        logic [31:0] wd;

        tbl[0] = '{0, 10'h000, 32'h0,        9, 128'h0};
        tbl[1] = '{1, 10'h000, 32'h000000FF, 6, 128'h0};
        tbl[2] = '{0, 10'h000, 32'h0,        9, {96'h0, 32'h000000FF}};
        tbl[3] = '{1, 10'h20F, 32'hA5A5A5A5, 6, {96'h0, 32'h000000FF}};
        tbl[4] = '{0, 10'h200, 32'h0,        9, {32'hA5A5A5A5, 96'h0}};
        tbl[5] = '{0, 10'h000, 32'h0,        9, {96'h0, 32'h000000FF}};

        @(negedge clk);
        do_reset(2, "reset");

        for (int i = 0; i < 6; i++) begin
            do_req(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].lat, tbl[i].rdata,
                   $sformatf("vec%0d", i));
            if (tbl[i].wr) model_mem[tbl[i].addr[9:2]] = tbl[i].wdata;
            else exp_rdata4 = tbl[i].rdata;
        end

        // Held req_valid: two back-to-back reads of 0x200.
        write_i = 1'b0;
        addr_i  = 10'h200;
        valid4  = 1'b1;
        pulses = 0; ready_cnt = 0; p_first = 0; p_second = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 20) valid4 = 1'b0;
            if (k < 20 && ready4) ready_cnt++;
            if (rv4) begin
                pulses++;
                if (pulses == 1) p_first = k; else p_second = k;
                check($sformatf("held_rdata_%0d", pulses), rdata4, model_block(10'h200));
            end
        end
        check("held_pulse_count", pulses, 2);
        check("held_pulse_spacing", p_second - p_first, 10);
        check("held_ready_gap", ready_cnt, 1);
        exp_rdata4 = model_block(10'h200);
        @(negedge clk);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 10'(($urandom_range(0, 3) << 8) | $urandom_range(0, 63));
            wd = $urandom;
            if (wr) begin
                do_req(0, 1, a, wd, 6, exp_rdata4, $sformatf("rnd%0d_wr", i));
                model_mem[a[9:2]] = wd;
            end else begin
                exp_rdata4 = model_block(a);
                do_req(0, 0, a, wd, 9, exp_rdata4, $sformatf("rnd%0d_rd", i));
            end
        end

        // Reset in the middle of a BEAT phase.
        do_req(0, 1, 10'h004, 32'h12345678, 6, exp_rdata4, "pre_rst_wr");
        write_i = 1'b0;
        addr_i  = 10'h000;
        valid4  = 1'b1;
        n = 0;
        while (n < 6) begin
            @(negedge clk);
            n++;
            valid4 = 1'b0;
        end
        do_reset(1, "midbeat");
        do_req(0, 0, 10'h000, 32'h0, 9, 128'h0, "post_rst_rd");

        // LATENCY=1 instance: back-to-back write then read of word 65.
        do_req(1, 1, 10'h104, 32'hDEADBEEF, 3, exp_rdata1, "l1_wr");
        exp_rdata1 = {64'h0, 32'hDEADBEEF, 32'h0};
        do_req(1, 0, 10'h104, 32'h0, 6, exp_rdata1, "l1_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
